// File: rtl/spi_slave.sv
// SPI mode-0 slave with a one-byte transmit holding register.
// All SPI pins are resynchronised into clk; edges are detected on the synchronised copies.
module spi_slave (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ss_n,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t     state;
  logic [2:0] sclk_sync;
  logic [2:0] ss_sync;
  logic [1:0] mosi_sync;
  logic [1:0] warm;
  logic       armed;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [7:0] hold_data;
  logic       hold_full;
  logic [2:0] bit_cnt;

  logic sclk_rise;
  logic sclk_fall;
  logic ss_fall;
  logic in_active;
  logic load;
  logic write;

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  // A stale-low ss_n seen right after reset must not start a frame: only arm once ss_n was seen high.
  assign ss_fall   = ~ss_sync[1] & ss_sync[2] & armed;
  assign in_active = (state == ACTIVE) && !ss_sync[1];
  assign load      = ((state == IDLE) && ss_fall) ||
                     (in_active && sclk_fall && (bit_cnt == 3'd0));
  assign write     = tx_valid && !hold_full;

  assign tx_ready  = ~hold_full;
  assign miso_oe   = (state == ACTIVE);
  assign miso      = (state == ACTIVE) & tx_shift[7];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= 3'b000;
      ss_sync   <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk};
      ss_sync   <= {ss_sync[1:0], ss_n};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      warm        <= 2'd0;
      armed       <= 1'b0;
      tx_shift    <= 8'h00;
      rx_shift    <= 8'h00;
      hold_data   <= 8'h00;
      hold_full   <= 1'b0;
      bit_cnt     <= 3'd0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      // Wait until the synchroniser holds real pin values before arming.
      if (warm != 2'd3) begin
        warm <= warm + 2'd1;
      end else if (ss_sync[1]) begin
        armed <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (ss_fall) state <= ACTIVE;
        end
        ACTIVE: begin
          if (ss_sync[1]) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            rx_shift <= 8'h00;
          end else begin
            if (sclk_rise) begin
              rx_shift <= {rx_shift[6:0], mosi_sync[1]};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= {rx_shift[6:0], mosi_sync[1]};
                rx_valid <= 1'b1;
              end
            end
            if (sclk_fall && (bit_cnt != 3'd0)) tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase

      // A write landing on the load cycle bypasses the holding register.
      if (load) begin
        if (hold_full) begin
          tx_shift  <= hold_data;
          hold_full <= 1'b0;
        end else if (write) begin
          tx_shift <= tx_data;
        end else begin
          tx_shift    <= 8'h00;
          tx_underrun <= 1'b1;
        end
      end else if (write) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a mode-0 master model drives bytes, received bytes go through an expected queue.
module tb_spi_slave;

  localparam int H = 50;

  logic       clk;
  logic       reset;
  logic       sclk;
  logic       mosi;
  logic       ss_n;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_underrun;
  logic [7:0] rx_data;
  logic       rx_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rx_cnt = 0;
  int underrun_cnt = 0;
  int rise_cyc = 0;
  int valid_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_last = 8'h00;

  spi_slave dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun), .rx_data(rx_data), .rx_valid(rx_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    reset = 1'b0; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
    tx_data = 8'h00; tx_valid = 1'b0;
  end

  // scoreboard: every rx_valid pulse pops one expected byte
  always @(negedge clk) begin
    if (reset && rx_valid) begin
      logic [7:0] exp;
      rx_cnt++;
      valid_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected got %h expected no byte", rx_data);
      end else begin
        exp = exp_q.pop_front();
        if (rx_data !== exp) begin
          errors++;
          $display("FAIL rx_data got %h expected %h", rx_data, exp);
        end
      end
    end
    if (tx_underrun === 1'b1) underrun_cnt++;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog simulation exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_hold(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (!tx_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL write_hold_ready got %b expected 1", tx_ready);
    end
    tx_data = b; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic ss_low;
    @(negedge clk);
    ss_n = 1'b0;
    wait_clks(H);
  endtask

  task automatic ss_high;
    wait_clks(H);
    ss_n = 1'b1;
    wait_clks(10);
  endtask

  task automatic spi_xfer(input logic [7:0] mo, input int nbits, input bit inject,
                          input logic [7:0] inj_b, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      wait_clks(H);
      mi[7-i] = miso;
      sclk = 1'b1;
      rise_cyc = cyc;
      wait_clks(H);
      sclk = 1'b0;
      if (inject && i == nbits - 1) begin
        wait_clks(2);
        tx_data = inj_b; tx_valid = 1'b1;
        checks++;
        if (tx_ready !== 1'b1) begin
          errors++;
          $display("FAIL inject_ready_before got %b expected 1", tx_ready);
        end
        wait_clks(1);
        tx_valid = 1'b0;
        checks++;
        if (tx_ready !== 1'b1) begin
          errors++;
          $display("FAIL inject_ready_after got %b expected 1", tx_ready);
        end
      end
    end
  endtask

  // tests
  task automatic test_reset;
    wait_clks(5);
    checks++;
    if ({rx_data, rx_valid, tx_underrun, tx_ready, miso, miso_oe} !== {8'h00, 5'b00100}) begin
      errors++;
      $display("FAIL reset_values got %h %b%b%b%b%b expected 00 00100",
               rx_data, rx_valid, tx_underrun, tx_ready, miso, miso_oe);
    end
    reset = 1'b1;
    wait_clks(10);
  endtask

  task automatic test_basic;
    logic [7:0] mi;
    int r0;
    write_hold(8'hA5);
    r0 = rx_cnt;
    exp_q.push_back(8'h3C);
    ss_low;
    spi_xfer(8'h3C, 8, 1'b0, 8'h00, mi);
    wait_clks(10);
    checks++;
    if (mi !== 8'hA5) begin errors++; $display("FAIL basic_miso got %h expected a5", mi); end
    checks++;
    if (rx_cnt - r0 !== 1) begin errors++; $display("FAIL basic_rx_count got %0d expected 1", rx_cnt - r0); end
    checks++;
    if (valid_cyc - rise_cyc !== 3) begin errors++; $display("FAIL basic_latency got %0d expected 3", valid_cyc - rise_cyc); end
    checks++;
    if (miso_oe !== 1'b1) begin errors++; $display("FAIL basic_oe_active got %b expected 1", miso_oe); end
    ss_high;
    exp_last = 8'h3C;
    checks++;
    if (miso_oe !== 1'b0) begin errors++; $display("FAIL basic_oe_idle got %b expected 0", miso_oe); end
    checks++;
    if (rx_data !== 8'h3C) begin errors++; $display("FAIL basic_rx_hold got %h expected 3c", rx_data); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] mi1, mi2;
    int r0;
    write_hold(8'hC3);
    r0 = rx_cnt;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    ss_low;
    write_hold(8'h5A);
    spi_xfer(8'h01, 8, 1'b0, 8'h00, mi1);
    spi_xfer(8'h80, 8, 1'b0, 8'h00, mi2);
    ss_high;
    exp_last = 8'h80;
    checks++;
    if (mi1 !== 8'hC3) begin errors++; $display("FAIL b2b_miso1 got %h expected c3", mi1); end
    checks++;
    if (mi2 !== 8'h5A) begin errors++; $display("FAIL b2b_miso2 got %h expected 5a", mi2); end
    checks++;
    if (rx_cnt - r0 !== 2) begin errors++; $display("FAIL b2b_rx_count got %0d expected 2", rx_cnt - r0); end
    checks++;
    if (rx_data !== 8'h80) begin errors++; $display("FAIL b2b_rx_data got %h expected 80", rx_data); end
  endtask

  task automatic test_underrun;
    logic [7:0] mi;
    int r0, u0;
    r0 = rx_cnt;
    u0 = underrun_cnt;
    exp_q.push_back(8'h96);
    ss_low;
    spi_xfer(8'h96, 8, 1'b0, 8'h00, mi);
    checks++;
    if (underrun_cnt - u0 !== 1) begin errors++; $display("FAIL underrun_count got %0d expected 1", underrun_cnt - u0); end
    checks++;
    if (mi !== 8'h00) begin errors++; $display("FAIL underrun_miso got %h expected 00", mi); end
    ss_high;
    exp_last = 8'h96;
    checks++;
    if (rx_cnt - r0 !== 1) begin errors++; $display("FAIL underrun_rx_count got %0d expected 1", rx_cnt - r0); end
  endtask

  task automatic test_abort;
    logic [7:0] mi;
    int r0;
    write_hold(8'hE7);
    r0 = rx_cnt;
    ss_low;
    spi_xfer(8'hB0, 5, 1'b0, 8'h00, mi);
    ss_high;
    checks++;
    if ((mi & 8'hF8) !== 8'hE0) begin errors++; $display("FAIL abort_miso got %h expected e0", mi & 8'hF8); end
    checks++;
    if (rx_cnt !== r0) begin errors++; $display("FAIL abort_rx_count got %0d expected %0d", rx_cnt, r0); end
    checks++;
    if (rx_data !== exp_last) begin errors++; $display("FAIL abort_rx_data got %h expected %h", rx_data, exp_last); end
    write_hold(8'h4D);
    exp_q.push_back(8'h69);
    ss_low;
    spi_xfer(8'h69, 8, 1'b0, 8'h00, mi);
    ss_high;
    exp_last = 8'h69;
    checks++;
    if (mi !== 8'h4D) begin errors++; $display("FAIL abort_next_miso got %h expected 4d", mi); end
    checks++;
    if (rx_cnt - r0 !== 1) begin errors++; $display("FAIL abort_next_count got %0d expected 1", rx_cnt - r0); end
  endtask

  task automatic test_tx_coincident;
    logic [7:0] mi1, mi2;
    int r0, u0;
    write_hold(8'h11);
    r0 = rx_cnt;
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hB2);
    ss_low;
    u0 = underrun_cnt;
    spi_xfer(8'hA1, 8, 1'b1, 8'h22, mi1);
    spi_xfer(8'hB2, 8, 1'b0, 8'h00, mi2);
    checks++;
    if (underrun_cnt - u0 !== 0) begin errors++; $display("FAIL coincide_underrun got %0d expected 0", underrun_cnt - u0); end
    ss_high;
    exp_last = 8'hB2;
    checks++;
    if (mi1 !== 8'h11) begin errors++; $display("FAIL coincide_miso1 got %h expected 11", mi1); end
    checks++;
    if (mi2 !== 8'h22) begin errors++; $display("FAIL coincide_miso2 got %h expected 22", mi2); end
    checks++;
    if (rx_cnt - r0 !== 2) begin errors++; $display("FAIL coincide_rx_count got %0d expected 2", rx_cnt - r0); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] mi;
    int r0;
    write_hold(8'h3F);
    ss_low;
    write_hold(8'hC0);
    spi_xfer(8'hFF, 3, 1'b0, 8'h00, mi);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({rx_data, rx_valid, tx_underrun, tx_ready, miso, miso_oe} !== {8'h00, 5'b00100}) begin
      errors++;
      $display("FAIL reset_mid_values got %h %b%b%b%b%b expected 00 00100",
               rx_data, rx_valid, tx_underrun, tx_ready, miso, miso_oe);
    end
    wait_clks(5);
    reset = 1'b1;
    exp_last = 8'h00;
    wait_clks(10);
    r0 = rx_cnt;
    spi_xfer(8'h5A, 8, 1'b0, 8'h00, mi);
    wait_clks(10);
    checks++;
    if (rx_cnt !== r0) begin errors++; $display("FAIL reset_stale_rx got %0d expected %0d", rx_cnt, r0); end
    checks++;
    if ({mi, miso_oe} !== 9'h000) begin errors++; $display("FAIL reset_stale_tx got %h %b expected 00 0", mi, miso_oe); end
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_stale_rx_data got %h expected 00", rx_data); end
    ss_n = 1'b1;
    wait_clks(20);
    write_hold(8'h9C);
    exp_q.push_back(8'hC9);
    ss_low;
    spi_xfer(8'hC9, 8, 1'b0, 8'h00, mi);
    ss_high;
    exp_last = 8'hC9;
    checks++;
    if (mi !== 8'h9C) begin errors++; $display("FAIL reset_fresh_miso got %h expected 9c", mi); end
    checks++;
    if (rx_data !== 8'hC9) begin errors++; $display("FAIL reset_fresh_rx got %h expected c9", rx_data); end
  endtask

  initial begin
    #1;
    test_reset;
    test_basic;
    test_back_to_back;
    test_underrun;
    test_abort;
    test_tx_coincident;
    test_reset_mid;
    wait_clks(10);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL rx_missing got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
